dram_load_scheduler: RTL and testbench
======================================

# dram_load_scheduler

Sequences DRAM-to-BRAM loads for the accelerator's on-chip memories (filter, feature, sparse index). It arbitrates round-robin between load requesters and issues word-by-word DRAM read addresses under an outstanding-read limit. It steers returned beats into the `dram_to_memory` packer, which it clears before each job, and converts the packer's write strobes into a BRAM address and per-requester write enables.

## Interface
- `NUM_REQ`, 3, number of load requesters
- `ADDR_WIDTH`, 32, DRAM byte-address width
- `LEN_WIDTH`, 16, job length in packed output words
- `BRAM_ADDR_WIDTH`, 10, BRAM word-address width
- `DATA_IN_BITWIDTH`, 32, DRAM beat width; also the address stride in bytes/8
- `DATA_OUT_BITWIDTH`, 163, packed BRAM word width
- `MAX_OUTSTANDING`, 8, maximum issued-but-unreturned reads

- `clk_i`  in  1  single clock
- `load_sched_rst_n_i`  in  1  asynchronous, active-low reset
- `req_i`  in  NUM_REQ  level request per requester; held until `done_o`
- `req_base_addr_i`  in  NUM_REQ*ADDR_WIDTH  per-requester DRAM base address
- `req_len_i`  in  NUM_REQ*LEN_WIDTH  per-requester packed-word count
- `grant_o`  out  NUM_REQ  one-hot current owner
- `done_o`  out  NUM_REQ  one-cycle completion pulse
- `dram_rd_valid_o`  out  1  read request valid
- `dram_rd_addr_o`  out  ADDR_WIDTH  read address
- `dram_rd_ready_i`  in  1  read request accepted when high with valid
- `dram_data_valid_i`  in  1  in-order read beat returned
- `packer_rst_o`  out  1  synchronous active-high clear to packer
- `packer_valid_o`  out  1  beat forward to packer `data_valid_i`
- `packer_we_i`  in  1  packer `memory_write_enable`
- `bram_addr_o`  out  BRAM_ADDR_WIDTH  write address
- `bram_we_o`  out  NUM_REQ  per-requester BRAM write enable
- `error_o`  out  1  sticky timeout flag

## Operation
- `BEATS_PER_WORD` = ceil(DATA_OUT_BITWIDTH/DATA_IN_BITWIDTH); each job reads len*BEATS_PER_WORD beats, counted in a LEN_WIDTH+4-bit counter.
- The FSM has five states: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE:
  - If any `req_i` is high, the round-robin arbiter picks a winner. Priority starts at the index one above the last winner.
  - The winner's base and length are latched, `grant_o` is set, and the FSM moves to CLEAR.
- CLEAR: `packer_rst_o`=1 for one cycle; the BRAM address and the read, return, and write counters are zeroed.
  - If len==0, go to DONE.
  - Otherwise go to ISSUE.
- ISSUE:
  - `dram_rd_valid_o`=1 while issued<total and outstanding<MAX_OUTSTANDING.
  - The address is base + issued*(DATA_IN_BITWIDTH/8).
  - On the last accepted request, go to DRAIN.
- DRAIN: wait until writes==len, then go to DONE.
- DONE:
  - `done_o[owner]` pulses.
  - `grant_o` clears the next cycle and the FSM returns to IDLE.
- `packer_valid_o` = `dram_data_valid_i` while `grant_o`≠0; beats arriving with no owner are dropped.
- `bram_we_o` = `packer_we_i` ? `grant_o` : 0, combinationally.
- `bram_addr_o` is registered and increments after each `packer_we_i`, wrapping modulo 2^BRAM_ADDR_WIDTH.
- The outstanding count is incremented on accept and decremented on return. If both happen in the same cycle, the count is unchanged.
- The outstanding count never exceeds MAX_OUTSTANDING and never underflows.
- A request deasserted mid-job is ignored; the job runs to completion.

## Timing
- Reset values:
  - FSM in IDLE
  - `grant_o`=0, `done_o`=0, `dram_rd_valid_o`=0, `dram_rd_addr_o`=0, `packer_rst_o`=0, `bram_addr_o`=0, `error_o`=0
  - all counters 0
  - round-robin pointer 0
- Assertion of `load_sched_rst_n_i` mid-job aborts immediately.
- Job start latency:
  - Request seen in IDLE (cycle 0).
  - `grant_o` at cycle 1 (CLEAR).
  - First `dram_rd_valid_o` at cycle 2.
- `dram_rd_addr_o` is stable while valid is high and ready is low.
- `done_o` is asserted in the cycle after the final `packer_we_i`.
- At most one job is in flight at a time; there is no overlap between the CLEAR of job N+1 and the DRAIN of job N.

## Configuration
- `LOAD_SCHED_TIMEOUT_EN` defined:
  - A 16-bit watchdog counts DRAIN cycles with no `packer_we_i`.
  - At 0xFFFF it sets `error_o`, pulses `done_o[owner]`, and returns to IDLE.
  - `error_o` clears only on reset.
- Undefined: `error_o` is tied to 0 and DRAIN waits indefinitely.

## Structure
- Package `load_sched_pkg`:
  - FSM state enum
  - `BEATS_PER_WORD` ceiling function
  - `ADDR_STRIDE` constant
- Sub-module `round_robin_arbiter` (NUM_REQ requests, one-hot grant, pointer update on an `advance` input).

## Test plan
- Single job: req[0], base 0x1000, len 2, DRAM ready always, 1-cycle return latency, packer model asserting we every 6th beat.
  - Expect 12 reads at 0x1000–0x102C step 4.
  - Expect `bram_we_o`=001 at addresses 0 and 1.
  - Expect `done_o[0]` one cycle after the 2nd write.
- Round-robin: req=111 held. Expect grant order 001,010,100,001 and no overlap of jobs.
- Backpressure: ready low for 20 cycles, returns stalled.
  - Expect outstanding to stop at 8.
  - Expect the address held stable.
  - Expect no lost or duplicated beats.
- len=0 on req[1]: expect CLEAR then DONE, zero DRAM reads, and `done_o[1]` at cycle 2.
- Reset mid-ISSUE: expect all outputs at reset values in the same cycle, and a clean restart of a subsequent job at BRAM address 0.
- With `LOAD_SCHED_TIMEOUT_EN`, packer never writes: expect `error_o`=1 and `done_o` after 65535 DRAIN cycles.

Source files
------------

// File: rtl/load_sched_pkg.sv
// Shared types and helpers for the DRAM-to-BRAM load scheduler.
// Holds the scheduler FSM state type, the beats-per-word ceiling and the DRAM address stride.
package load_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StIssue,
    StDrain,
    StDone
  } sched_state_e;

  function automatic int unsigned beats_per_word(input int unsigned out_w,
                                                 input int unsigned in_w);
    return (out_w + in_w - 1) / in_w;
  endfunction

  function automatic int unsigned addr_stride(input int unsigned in_w);
    return in_w / 8;
  endfunction

  // Byte stride between consecutive beats for the default 32-bit DRAM beat.
  localparam int unsigned ADDR_STRIDE = addr_stride(32);

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with a one-hot grant; the priority pointer moves to one above the
// winner whenever advance_i is high and at least one request is present.
module round_robin_arbiter #(
  parameter int unsigned NumReq = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  input  logic              advance_i,
  output logic [NumReq-1:0] gnt_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] win_idx;
  logic            found;
  int unsigned     idx;

  // Scan requests starting at the pointer; the first one found wins.
  always_comb begin
    gnt_o   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = (32'(ptr_q) + i) % NumReq;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win_idx    = IdxW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dram_load_scheduler.sv
// Sequences DRAM-to-BRAM load jobs: arbitrates requesters, issues beat reads under an
// outstanding limit and steers packer writes to BRAM. Define LOAD_SCHED_TIMEOUT_EN for the DRAIN
// watchdog that raises error_o.
module dram_load_scheduler
  import load_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ           = 3,
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned LEN_WIDTH         = 16,
  parameter int unsigned BRAM_ADDR_WIDTH   = 10,
  parameter int unsigned DATA_IN_BITWIDTH  = 32,
  parameter int unsigned DATA_OUT_BITWIDTH = 163,
  parameter int unsigned MAX_OUTSTANDING   = 8
) (
  input  logic                            clk_i,
  input  logic                            load_sched_rst_n_i,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_base_addr_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len_i,
  output logic [NUM_REQ-1:0]              grant_o,
  output logic [NUM_REQ-1:0]              done_o,
  output logic                            dram_rd_valid_o,
  output logic [ADDR_WIDTH-1:0]           dram_rd_addr_o,
  input  logic                            dram_rd_ready_i,
  input  logic                            dram_data_valid_i,
  output logic                            packer_rst_o,
  output logic                            packer_valid_o,
  input  logic                            packer_we_i,
  output logic [BRAM_ADDR_WIDTH-1:0]      bram_addr_o,
  output logic [NUM_REQ-1:0]              bram_we_o,
  output logic                            error_o
);

  localparam int unsigned Beats  = beats_per_word(DATA_OUT_BITWIDTH, DATA_IN_BITWIDTH);
  localparam int unsigned Stride = addr_stride(DATA_IN_BITWIDTH);
  localparam int unsigned CntW   = LEN_WIDTH + 4;
  localparam int unsigned OutW   = $clog2(MAX_OUTSTANDING + 1);

  sched_state_e               state_q, state_d;
  logic [NUM_REQ-1:0]         grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]      base_q, base_d;
  logic [LEN_WIDTH-1:0]       len_q, len_d;
  logic [LEN_WIDTH-1:0]       writes_q, writes_d;
  logic [CntW-1:0]            issued_q, issued_d;
  logic [OutW-1:0]            outst_q, outst_d;
  logic [BRAM_ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;

  logic [CntW-1:0]    total;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_advance;
  logic               rd_accept;
  logic               beat_ret;
  logic               outst_dec;

`ifdef LOAD_SCHED_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
  logic        error_q, error_d;
`endif

  round_robin_arbiter #(
    .NumReq(NUM_REQ)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_ni   (load_sched_rst_n_i),
    .req_i    (req_i),
    .advance_i(arb_advance),
    .gnt_o    (arb_gnt)
  );

  assign arb_advance = (state_q == StIdle) && (|req_i);
  assign total       = CntW'(len_q) * CntW'(Beats);

  // Beats with no owner are dropped and never touch the outstanding count.
  assign beat_ret  = dram_data_valid_i && (grant_q != '0);
  assign outst_dec = beat_ret && (outst_q != '0);

  assign dram_rd_valid_o = (state_q == StIssue) && (issued_q < total) &&
                           (outst_q < OutW'(MAX_OUTSTANDING));
  assign rd_accept       = dram_rd_valid_o && dram_rd_ready_i;
  assign dram_rd_addr_o  = base_q + ADDR_WIDTH'(issued_q) * ADDR_WIDTH'(Stride);

  assign packer_rst_o   = (state_q == StClear);
  assign packer_valid_o = beat_ret;
  assign bram_we_o      = packer_we_i ? grant_q : '0;
  assign bram_addr_o    = bram_addr_q;
  assign grant_o        = grant_q;
  assign done_o         = (state_q == StDone) ? grant_q : '0;

`ifdef LOAD_SCHED_TIMEOUT_EN
  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    base_d      = base_q;
    len_d       = len_q;
    issued_d    = rd_accept ? issued_q + CntW'(1) : issued_q;
    writes_d    = packer_we_i ? writes_q + LEN_WIDTH'(1) : writes_q;
    bram_addr_d = packer_we_i ? bram_addr_q + BRAM_ADDR_WIDTH'(1) : bram_addr_q;
    outst_d     = outst_q;
    case ({rd_accept, outst_dec})
      2'b10:   outst_d = outst_q + OutW'(1);
      2'b01:   outst_d = outst_q - OutW'(1);
      default: outst_d = outst_q;
    endcase
`ifdef LOAD_SCHED_TIMEOUT_EN
    wdog_d  = wdog_q;
    error_d = error_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          grant_d = arb_gnt;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
              base_d = req_base_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
              len_d  = req_len_i[i*LEN_WIDTH +: LEN_WIDTH];
            end
          end
          state_d = StClear;
        end
      end
      StClear: begin
        bram_addr_d = '0;
        issued_d    = '0;
        writes_d    = '0;
        outst_d     = '0;
`ifdef LOAD_SCHED_TIMEOUT_EN
        wdog_d      = '0;
`endif
        state_d     = (len_q == '0) ? StDone : StIssue;
      end
      StIssue: begin
        if (rd_accept && (issued_q + CntW'(1) == total)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave on the final write so done_o lands in the very next cycle.
        if (packer_we_i && (writes_q + LEN_WIDTH'(1) == len_q)) begin
          state_d = StDone;
        end
`ifdef LOAD_SCHED_TIMEOUT_EN
        if (packer_we_i) begin
          wdog_d = '0;
        end else if (wdog_q == 16'hFFFF) begin
          error_d = 1'b1;
          state_d = StDone;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      StDone: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge load_sched_rst_n_i) begin
    if (!load_sched_rst_n_i) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      writes_q    <= '0;
      outst_q     <= '0;
      bram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      writes_q    <= writes_d;
      outst_q     <= outst_d;
      bram_addr_q <= bram_addr_d;
    end
  end

`ifdef LOAD_SCHED_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge load_sched_rst_n_i) begin
    if (!load_sched_rst_n_i) begin
      wdog_q  <= '0;
      error_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      error_q <= error_d;
    end
  end
`endif

endmodule

// File: tb/tb_dram_load_scheduler.sv
// Directed self-checking bench for dram_load_scheduler with a DRAM return model and a packer
// model that writes on every 6th forwarded beat.
module tb_dram_load_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [95:0] base_flat;
  logic [47:0] len_flat;
  logic [2:0]  grant, done, bram_we;
  logic        rd_valid, rd_ready, data_valid;
  logic [31:0] rd_addr;
  logic        packer_rst, packer_valid, packer_we;
  logic [9:0]  bram_addr;
  logic        error;

  logic        ret_en;
  logic        pk_never;
  int          pend, pend_n, pend_max;
  int          pk_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] rd_log[$];
  logic [9:0]  wr_addr_log[$];
  logic [2:0]  wr_we_log[$];
  int          wr_cyc_log[$];
  int          done_cyc_log[$];
  int          cyc = 0;
  int          beats_fwd = 0;
  int          overlap_err = 0;
  int          addr_chg = 0;
  logic [2:0]  prev_grant = '0;
  logic        held_v = 1'b0;
  logic [31:0] held_addr = '0;

  always #5 clk = ~clk;

  dram_load_scheduler dut (
    .clk_i             (clk),
    .load_sched_rst_n_i(rst_n),
    .req_i             (req),
    .req_base_addr_i   (base_flat),
    .req_len_i         (len_flat),
    .grant_o           (grant),
    .done_o            (done),
    .dram_rd_valid_o   (rd_valid),
    .dram_rd_addr_o    (rd_addr),
    .dram_rd_ready_i   (rd_ready),
    .dram_data_valid_i (data_valid),
    .packer_rst_o      (packer_rst),
    .packer_valid_o    (packer_valid),
    .packer_we_i       (packer_we),
    .bram_addr_o       (bram_addr),
    .bram_we_o         (bram_we),
    .error_o           (error)
  );

  // DRAM: in-order beats, one cycle after accept when returns are enabled.
  assign pend_n = pend + int'(rd_valid && rd_ready) - int'(data_valid);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 0;
      data_valid <= 1'b0;
    end else begin
      pend       <= pend_n;
      data_valid <= ret_en && (pend_n > 0);
    end
  end

  assign packer_we = packer_valid && (pk_cnt == 5) && !pk_never;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pk_cnt <= 0;
    else if (packer_rst)   pk_cnt <= 0;
    else if (packer_valid) pk_cnt <= (pk_cnt == 5) ? 0 : pk_cnt + 1;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      prev_grant = '0;
      held_v     = 1'b0;
    end else begin
      if (rd_valid && rd_ready) rd_log.push_back(rd_addr);
      if (bram_we != '0) begin
        wr_addr_log.push_back(bram_addr);
        wr_we_log.push_back(bram_we);
        wr_cyc_log.push_back(cyc);
      end
      if (done != '0) done_cyc_log.push_back(cyc);
      if (packer_valid) beats_fwd++;
      if (pend > pend_max) pend_max = pend;
      if (grant != '0 && prev_grant != '0 && grant != prev_grant) overlap_err++;
      prev_grant = grant;
      if (rd_valid && !rd_ready && held_v && rd_addr != held_addr) addr_chg++;
      held_v    = rd_valid && !rd_ready;
      held_addr = rd_addr;
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_addr_log.delete();
    wr_we_log.delete();
    wr_cyc_log.delete();
    done_cyc_log.delete();
    beats_fwd = 0;
    pend_max  = 0;
  endtask

  task automatic wait_done(input int budget, output logic [2:0] seen);
    seen = '0;
    for (int i = 0; i < budget && seen == '0; i++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_seen", 64'(seen != '0), 64'd1);
  endtask

  task automatic check_reads(input string tag, input logic [31:0] base, input int n);
    check({tag, "_rd_count"}, 64'(rd_log.size()), 64'(n));
    for (int i = 0; i < n && i < rd_log.size(); i++) begin
      check($sformatf("%s_rd_addr[%0d]", tag, i), 64'(rd_log[i]), 64'(base + 32'(4 * i)));
    end
  endtask

  task automatic check_writes(input string tag, input int n, input logic [2:0] we);
    check({tag, "_wr_count"}, 64'(wr_addr_log.size()), 64'(n));
    for (int i = 0; i < n && i < wr_addr_log.size(); i++) begin
      check($sformatf("%s_wr_addr[%0d]", tag, i), 64'(wr_addr_log[i]), 64'(i));
      check($sformatf("%s_wr_we[%0d]", tag, i), 64'(wr_we_log[i]), 64'(we));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation bound expired");
    $fatal(1);
  end

  initial begin
    logic [2:0] d;
    logic [2:0] rr_exp [4];
    rr_exp   = '{3'b001, 3'b010, 3'b100, 3'b001};
    req       = '0;
    base_flat = '0;
    len_flat  = '0;
    rd_ready  = 1'b1;
    ret_en    = 1'b1;
    pk_never  = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_packer_rst", 64'(packer_rst), 64'd0);
    check("rst_bram_addr", 64'(bram_addr), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single job: 2 words = 12 beats from 0x1000.
    clear_logs();
    base_flat[31:0] = 32'h1000;
    len_flat[15:0]  = 16'd2;
    req = 3'b001;
    @(negedge clk);
    check("job0_grant_c1", 64'(grant), 64'b001);
    check("job0_packer_rst_c1", 64'(packer_rst), 64'd1);
    @(negedge clk);
    check("job0_rd_valid_c2", 64'(rd_valid), 64'd1);
    check("job0_rd_addr_c2", 64'(rd_addr), 64'h1000);
    wait_done(200, d);
    check("job0_done", 64'(d), 64'b001);
    req = '0;
    @(negedge clk);
    check_reads("job0", 32'h1000, 12);
    check_writes("job0", 2, 3'b001);
    if (wr_cyc_log.size() == 2 && done_cyc_log.size() == 1) begin
      check("job0_done_latency", 64'(done_cyc_log[0] - wr_cyc_log[1]), 64'd1);
    end else begin
      check("job0_log_sizes", 64'(done_cyc_log.size()), 64'd1);
    end
    check("job0_grant_after", 64'(grant), 64'd0);

    // Zero-length job on requester 1: CLEAR then DONE, no reads.
    clear_logs();
    len_flat[31:16] = 16'd0;
    req = 3'b010;
    @(negedge clk);
    check("len0_grant_c1", 64'(grant), 64'b010);
    check("len0_packer_rst_c1", 64'(packer_rst), 64'd1);
    @(negedge clk);
    check("len0_done_c2", 64'(done), 64'b010);
    check("len0_rd_valid_c2", 64'(rd_valid), 64'd0);
    req = '0;
    repeat (3) @(negedge clk);
    check("len0_rd_count", 64'(rd_log.size()), 64'd0);

    // Reset in the middle of ISSUE, then a clean job from requester 2.
    clear_logs();
    base_flat[31:0] = 32'h4000;
    len_flat[15:0]  = 16'd4;
    req = 3'b001;
    for (int i = 0; i < 100 && bram_addr != 10'd1; i++) @(negedge clk);
    check("mid_pre_bram_addr", 64'(bram_addr), 64'd1);
    check("mid_pre_rd_valid", 64'(rd_valid), 64'd1);
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("mid_rst_grant", 64'(grant), 64'd0);
    check("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    check("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
    check("mid_rst_bram_addr", 64'(bram_addr), 64'd0);
    check("mid_rst_bram_we", 64'(bram_we), 64'd0);
    check("mid_rst_packer_valid", 64'(packer_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    base_flat[95:64] = 32'h5000;
    len_flat[47:32]  = 16'd1;
    req = 3'b100;
    wait_done(100, d);
    check("restart_done", 64'(d), 64'b100);
    req = '0;
    @(negedge clk);
    check_reads("restart", 32'h5000, 6);
    check_writes("restart", 1, 3'b100);

    // Round-robin with all three requesting; pointer restarts at 0 after the last winner (2).
    clear_logs();
    overlap_err = 0;
    base_flat = {32'h0000_8000, 32'h0000_7000, 32'h0000_6000};
    len_flat  = {16'd1, 16'd1, 16'd1};
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_done(100, d);
      check($sformatf("rr_grant[%0d]", k), 64'(d), 64'(rr_exp[k]));
    end
    req = '0;
    repeat (3) @(negedge clk);
    check("rr_overlap", 64'(overlap_err), 64'd0);
    check("rr_rd_count", 64'(rd_log.size()), 64'd24);
    check("rr_wr_count", 64'(wr_addr_log.size()), 64'd4);
    check("rr_error", 64'(error), 64'd0);

    // Backpressure: returns stalled, then ready low while beats drain.
    clear_logs();
    addr_chg = 0;
    base_flat[31:0] = 32'h3000;
    len_flat[15:0]  = 16'd2;
    ret_en = 1'b0;
    req = 3'b001;
    repeat (20) @(negedge clk);
    check("bp_outst_max", 64'(pend_max), 64'd8);
    check("bp_rd_count_stall", 64'(rd_log.size()), 64'd8);
    check("bp_rd_valid_full", 64'(rd_valid), 64'd0);
    rd_ready = 1'b0;
    ret_en   = 1'b1;
    repeat (20) @(negedge clk);
    check("bp_rd_valid_held", 64'(rd_valid), 64'd1);
    check("bp_rd_addr_held", 64'(rd_addr), 64'h3020);
    rd_ready = 1'b1;
    wait_done(200, d);
    check("bp_done", 64'(d), 64'b001);
    req = '0;
    @(negedge clk);
    check("bp_addr_changes", 64'(addr_chg), 64'd0);
    check("bp_outst_max_end", 64'(pend_max), 64'd8);
    check("bp_beats_fwd", 64'(beats_fwd), 64'd12);
    check_reads("bp", 32'h3000, 12);
    check_writes("bp", 2, 3'b001);

`ifdef LOAD_SCHED_TIMEOUT_EN
    // Packer never writes: the watchdog must end the job with error_o set.
    clear_logs();
    pk_never = 1'b1;
    base_flat[31:0] = 32'h9000;
    len_flat[15:0]  = 16'd1;
    req = 3'b001;
    wait_done(70000, d);
    check("to_done", 64'(d), 64'b001);
    check("to_error", 64'(error), 64'd1);
    req = '0;
    repeat (3) @(negedge clk);
    check("to_error_sticky", 64'(error), 64'd1);
    check("to_grant_idle", 64'(grant), 64'd0);
    pk_never = 1'b0;
`endif

    check("final_overlap", 64'(overlap_err), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
